// File: rtl/halt_pkg.sv
// ----------------------------------------------------------------------------
// halt_pkg
// Shared types and constants for the halt controller.
//   halt_state_t        : controller states (STEP only reachable when the
//                         HALT_SINGLE_STEP_EN build option is defined)
//   DEFAULT_HALT_OPCODE : instruction encoding treated as HALT by default
// ----------------------------------------------------------------------------
package halt_pkg;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        DRAIN  = 3'd1,
        HALTED = 3'd2,
        RESUME = 3'd3,
        STEP   = 3'd4
    } halt_state_t;

    localparam logic [31:0] DEFAULT_HALT_OPCODE = 32'hFFFF_FFFF;

endpackage

// File: rtl/halt_controller_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Registered up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : increment request for this cycle
//   count : current count value (registered)
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count register: increments on request unless already saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/halt_controller.sv
// ----------------------------------------------------------------------------
// halt_controller
// Watches the decode stage for the HALT opcode, stalls fetch, waits
// DRAIN_CYCLES for older instructions to retire, then sits in a sticky
// HALTED state exposing the captured HALT PC. A resume request produces a
// one-cycle fetch redirect to halt_pc+4. HALTED entries are counted with a
// saturating counter.
//
// Build option: HALT_SINGLE_STEP_EN adds the step_req input and the STEP
// state (redirect for one cycle with fetch released, then re-halt).
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   id_valid        : id_instr/id_pc hold a valid decode-stage instruction
//   id_instr, id_pc : decode-stage instruction and its PC
//   flush           : branch/jump flush, kills the decode-stage instruction
//   resume_req      : level request to leave HALTED
//   step_req        : (HALT_SINGLE_STEP_EN only) single-step request
//   stall_fetch     : freeze PC and IF/ID register
//   halted          : core fully halted
//   halt_pc         : captured HALT PC while halted, else 0
//   resume_valid    : one-cycle redirect pulse
//   resume_pc       : halt_pc+4 during the redirect pulse, else 0
//   halt_count      : saturating count of HALTED entries
// ----------------------------------------------------------------------------
module halt_controller
    import halt_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] HALT_OPCODE  = DEFAULT_HALT_OPCODE,
    parameter int              DRAIN_CYCLES = 3,
    parameter int              CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_instr,
    input  logic [XLEN-1:0]  id_pc,
    input  logic             flush,
    input  logic             resume_req,
`ifdef HALT_SINGLE_STEP_EN
    input  logic             step_req,
`endif
    output logic             stall_fetch,
    output logic             halted,
    output logic [XLEN-1:0]  halt_pc,
    output logic             resume_valid,
    output logic [XLEN-1:0]  resume_pc,
    output logic [CNT_W-1:0] halt_count
);

    // Drain counter must hold DRAIN_CYCLES; keep at least one bit when it is 0.
    localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);
    localparam bit            NO_DRAIN   = (DRAIN_CYCLES == 0);

    halt_state_t     state_r;
    logic [DW-1:0]   drain_cnt_r;
    logic [XLEN-1:0] pc_r;
    logic            detect_s;
    logic            enter_halt_s;
    logic [XLEN-1:0] next_pc_s;

    assign detect_s  = id_valid && (id_instr == HALT_OPCODE) && !flush;
    assign next_pc_s = pc_r + XLEN'(4);

`ifdef HALT_SINGLE_STEP_EN
    logic [XLEN-1:0] step_pc_s;

    // After a step, re-arm on the current decode PC, or the sequential PC if
    // decode holds nothing valid.
    assign step_pc_s = id_valid ? id_pc : next_pc_s;
`endif

    // Flags the cycle in which the FSM transitions into HALTED (counter bump).
    always_comb begin
        enter_halt_s = 1'b0;
        case (state_r)
            RUN:     enter_halt_s = detect_s && NO_DRAIN;
            DRAIN:   enter_halt_s = !flush && (drain_cnt_r == DW'(1));
`ifdef HALT_SINGLE_STEP_EN
            STEP:    enter_halt_s = NO_DRAIN;
`endif
            default: enter_halt_s = 1'b0;
        endcase
    end

    // Controller FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= RUN;
            drain_cnt_r  <= '0;
            pc_r         <= '0;
            stall_fetch  <= 1'b0;
            halted       <= 1'b0;
            halt_pc      <= '0;
            resume_valid <= 1'b0;
            resume_pc    <= '0;
        end else begin
            // Redirect outputs are pulses; only the leaving-HALTED branches raise them.
            resume_valid <= 1'b0;
            resume_pc    <= '0;
            case (state_r)
                RUN: begin
                    if (detect_s) begin
                        pc_r        <= id_pc;
                        stall_fetch <= 1'b1;
                        if (NO_DRAIN) begin
                            state_r <= HALTED;
                            halted  <= 1'b1;
                            halt_pc <= id_pc;
                        end else begin
                            state_r     <= DRAIN;
                            drain_cnt_r <= DRAIN_INIT;
                        end
                    end
                end
                DRAIN: begin
                    // A flush means the HALT itself was on a wrong path.
                    if (flush) begin
                        state_r     <= RUN;
                        pc_r        <= '0;
                        drain_cnt_r <= '0;
                        stall_fetch <= 1'b0;
                    end else if (drain_cnt_r == DW'(1)) begin
                        state_r     <= HALTED;
                        drain_cnt_r <= '0;
                        halted      <= 1'b1;
                        halt_pc     <= pc_r;
                    end else begin
                        drain_cnt_r <= drain_cnt_r - DW'(1);
                    end
                end
                HALTED: begin
                    if (resume_req) begin
                        state_r      <= RESUME;
                        halted       <= 1'b0;
                        halt_pc      <= '0;
                        resume_valid <= 1'b1;
                        resume_pc    <= next_pc_s;
`ifdef HALT_SINGLE_STEP_EN
                    end else if (step_req) begin
                        state_r      <= STEP;
                        halted       <= 1'b0;
                        halt_pc      <= '0;
                        stall_fetch  <= 1'b0;
                        resume_valid <= 1'b1;
                        resume_pc    <= next_pc_s;
`endif
                    end
                end
                RESUME: begin
                    state_r     <= RUN;
                    pc_r        <= '0;
                    stall_fetch <= 1'b0;
                end
`ifdef HALT_SINGLE_STEP_EN
                STEP: begin
                    pc_r        <= step_pc_s;
                    stall_fetch <= 1'b1;
                    if (NO_DRAIN) begin
                        state_r <= HALTED;
                        halted  <= 1'b1;
                        halt_pc <= step_pc_s;
                    end else begin
                        state_r     <= DRAIN;
                        drain_cnt_r <= DRAIN_INIT;
                    end
                end
`endif
                default: begin
                    state_r     <= RUN;
                    drain_cnt_r <= '0;
                    pc_r        <= '0;
                    stall_fetch <= 1'b0;
                    halted      <= 1'b0;
                    halt_pc     <= '0;
                end
            endcase
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_halt_count (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (enter_halt_s),
        .count (halt_count)
    );

endmodule
